// File: rtl/mttkrp_pe_v2_if.sv
// Bus bundle between a tensor/factor source + drain sink (master) and the
// MTTKRP processing element (slave).
interface mttkrp_pe_v2_if #(
  parameter int TENSOR_DIMENSIONS = 3,
  parameter int RANK              = 16,
  parameter int FACTOR_WIDTH      = 32,
  parameter int IDX_WIDTH         = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int ROW_BITS          = 10
);
  localparam int NF = TENSOR_DIMENSIONS - 1;

  logic                                             shard_start;
  logic                                             tensor_valid;
  logic                                             tensor_ready;
  logic                                             tensor_last;
  logic [TENSOR_DIMENSIONS*IDX_WIDTH+DATA_WIDTH-1:0] tensor_element;
  logic                                             fac_req_valid;
  logic [NF*IDX_WIDTH-1:0]                          fac_req_addr;
  logic [NF-1:0]                                    fac_rsp_valid;
  logic [NF*RANK*FACTOR_WIDTH-1:0]                  fac_rsp_data;
  logic                                             out_valid;
  logic                                             out_ready;
  logic [ROW_BITS-1:0]                              out_row;
  logic [RANK*FACTOR_WIDTH-1:0]                     out_data;
  logic                                             shard_done;
  logic                                             err_oob;

  modport master (
    output shard_start, tensor_valid, tensor_last, tensor_element,
           fac_rsp_valid, fac_rsp_data, out_ready,
    input  tensor_ready, fac_req_valid, fac_req_addr, out_valid,
           out_row, out_data, shard_done, err_oob
  );

  modport slave (
    input  shard_start, tensor_valid, tensor_last, tensor_element,
           fac_rsp_valid, fac_rsp_data, out_ready,
    output tensor_ready, fac_req_valid, fac_req_addr, out_valid,
           out_row, out_data, shard_done, err_oob
  );
endinterface

// File: rtl/mttkrp_pe_v2.sv
// Sparse MTTKRP processing element: one tensor element at a time is multiplied
// by its factor rows and accumulated into an on-chip output row buffer, then drained.
module mttkrp_pe_v2 #(
  parameter int TENSOR_DIMENSIONS = 3,
  parameter int RANK              = 16,
  parameter int FACTOR_WIDTH      = 32,
  parameter int IDX_WIDTH         = 16,
  parameter int DATA_WIDTH        = 32,
  parameter int ROW_BITS          = 10,
  parameter int SKIP_EMPTY        = 1
) (
  input  logic           clk,
  input  logic           rst,
  mttkrp_pe_v2_if.slave  bus
);
  localparam int NF   = TENSOR_DIMENSIONS - 1;
  localparam int LW   = RANK * FACTOR_WIDTH;
  localparam int CW   = TENSOR_DIMENSIONS * IDX_WIDTH;
  localparam int ROWS = 2 ** ROW_BITS;

  typedef enum logic [2:0] {
    IDLE, ACCEPT, FETCH, READ, COMPUTE, WRITE, DRAIN, DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_coord;
  logic [DATA_WIDTH-1:0] r_value;
  logic                r_last;
  logic [NF-1:0]       r_got;
  logic [LW-1:0]       r_factor [NF];
  logic [LW-1:0]       r_acc;
  logic [LW-1:0]       r_memRd;
  logic [LW-1:0]       r_outData;
  logic [ROWS-1:0]     r_touched;
  logic [ROW_BITS-1:0] r_scan;
  logic [ROW_BITS-1:0] r_outRow;
  logic                r_rdPending;
  logic                r_tensorReady;
  logic                r_facReqValid;
  logic                r_outValid;
  logic                r_shardDone;
  logic                r_errOob;
  logic [LW-1:0]       mem [ROWS];

  logic [IDX_WIDTH-1:0]    w_row;
  logic [ROW_BITS-1:0]     w_rowIdx;
  logic [ROW_BITS-1:0]     w_rdAddr;
  logic                    w_oob;
  logic [NF-1:0]           w_gotNext;
  logic [LW-1:0]           w_acc;
  logic [FACTOR_WIDTH-1:0] w_prod;

  assign w_row     = r_coord[CW-1 -: IDX_WIDTH];
  assign w_rowIdx  = ROW_BITS'(w_row);
  assign w_oob     = (w_row >> ROW_BITS) != '0;
  assign w_gotNext = r_got | bus.fac_rsp_valid;
  assign w_rdAddr  = (r_state == DRAIN) ? r_scan : w_rowIdx;

  assign bus.tensor_ready  = r_tensorReady;
  assign bus.fac_req_valid = r_facReqValid;
  assign bus.fac_req_addr  = r_coord[NF*IDX_WIDTH-1:0];
  assign bus.out_valid     = r_outValid;
  assign bus.out_row       = r_outRow;
  assign bus.out_data      = r_outData;
  assign bus.shard_done    = r_shardDone;
  assign bus.err_oob       = r_errOob;

  // Untouched rows start from zero, so stale memory never leaks into a new shard.
  always_comb begin
    w_acc  = '0;
    w_prod = '0;
    for (int r = 0; r < RANK; r++) begin
      w_prod = FACTOR_WIDTH'(r_value);
      for (int m = 0; m < NF; m++) begin
        w_prod = w_prod * r_factor[m][r*FACTOR_WIDTH +: FACTOR_WIDTH];
      end
      w_acc[r*FACTOR_WIDTH +: FACTOR_WIDTH] = r_touched[w_rowIdx]
        ? r_memRd[r*FACTOR_WIDTH +: FACTOR_WIDTH] + w_prod
        : w_prod;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == WRITE) mem[w_rowIdx] <= r_acc;
    r_memRd <= mem[w_rdAddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_touched     <= '0;
      r_tensorReady <= 1'b0;
      r_facReqValid <= 1'b0;
      r_outValid    <= 1'b0;
      r_shardDone   <= 1'b0;
      r_errOob      <= 1'b0;
      r_outRow      <= '0;
      r_scan        <= '0;
      r_rdPending   <= 1'b0;
      r_got         <= '0;
      r_last        <= 1'b0;
    end else begin
      r_facReqValid <= 1'b0;
      r_shardDone   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.shard_start) begin
            r_errOob      <= 1'b0;
            r_tensorReady <= 1'b1;
            r_state       <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (bus.tensor_valid && r_tensorReady) begin
            r_coord       <= bus.tensor_element[DATA_WIDTH +: CW];
            r_value       <= bus.tensor_element[DATA_WIDTH-1:0];
            r_last        <= bus.tensor_last;
            r_got         <= '0;
            r_tensorReady <= 1'b0;
            r_facReqValid <= 1'b1;
            r_state       <= FETCH;
          end
        end
        FETCH: begin
          for (int m = 0; m < NF; m++) begin
            if (bus.fac_rsp_valid[m] && !r_got[m]) begin
              r_factor[m] <= bus.fac_rsp_data[m*LW +: LW];
            end
          end
          r_got <= w_gotNext;
          if (&w_gotNext) begin
            if (w_oob) begin
              r_errOob <= 1'b1;
              if (r_last) begin
                r_state <= DRAIN;
              end else begin
                r_tensorReady <= 1'b1;
                r_state       <= ACCEPT;
              end
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: r_state <= COMPUTE;
        COMPUTE: begin
          r_acc   <= w_acc;
          r_state <= WRITE;
        end
        WRITE: begin
          r_touched[w_rowIdx] <= 1'b1;
          if (r_last) begin
            r_state <= DRAIN;
          end else begin
            r_tensorReady <= 1'b1;
            r_state       <= ACCEPT;
          end
        end
        // Emitted rows take a read cycle then a present cycle; skipped rows take one.
        DRAIN: begin
          if (r_outValid) begin
            if (bus.out_ready) begin
              r_outValid        <= 1'b0;
              r_touched[r_scan] <= 1'b0;
              r_scan            <= r_scan + 1'b1;
              if (r_scan == '1) begin
                r_state     <= DONE;
                r_shardDone <= 1'b1;
              end
            end
          end else if (r_rdPending) begin
            r_rdPending <= 1'b0;
            r_outValid  <= 1'b1;
            r_outRow    <= r_scan;
            r_outData   <= r_touched[r_scan] ? r_memRd : '0;
          end else if (SKIP_EMPTY != 0 && !r_touched[r_scan]) begin
            r_scan <= r_scan + 1'b1;
            if (r_scan == '1) begin
              r_state     <= DONE;
              r_shardDone <= 1'b1;
            end
          end else begin
            r_rdPending <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mttkrp_pe_v2.sv
// Self-checking bench for mttkrp_pe_v2: one instance drains touched rows only,
// a second drains every row; only one is out of reset at a time.
module tb_mttkrp_pe_v2;
  localparam int N   = 3;
  localparam int RK  = 4;
  localparam int FW  = 32;
  localparam int IDX = 16;
  localparam int DW  = 32;
  localparam int RB  = 4;
  localparam int LW  = RK * FW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB;

  mttkrp_pe_v2_if #(.TENSOR_DIMENSIONS(N), .RANK(RK), .FACTOR_WIDTH(FW),
                    .IDX_WIDTH(IDX), .DATA_WIDTH(DW), .ROW_BITS(RB)) ifA ();
  mttkrp_pe_v2_if #(.TENSOR_DIMENSIONS(N), .RANK(RK), .FACTOR_WIDTH(FW),
                    .IDX_WIDTH(IDX), .DATA_WIDTH(DW), .ROW_BITS(RB)) ifB ();

  mttkrp_pe_v2 #(.TENSOR_DIMENSIONS(N), .RANK(RK), .FACTOR_WIDTH(FW), .IDX_WIDTH(IDX),
                 .DATA_WIDTH(DW), .ROW_BITS(RB), .SKIP_EMPTY(1))
    dutA (.clk(clk), .rst(rstA), .bus(ifA.slave));
  mttkrp_pe_v2 #(.TENSOR_DIMENSIONS(N), .RANK(RK), .FACTOR_WIDTH(FW), .IDX_WIDTH(IDX),
                 .DATA_WIDTH(DW), .ROW_BITS(RB), .SKIP_EMPTY(0))
    dutB (.clk(clk), .rst(rstB), .bus(ifB.slave));

  logic                  shardStart, tValid, tLast, outReady;
  logic [N*IDX+DW-1:0]   tElem;
  logic [1:0]            rspValid;
  logic [2*LW-1:0]       rspData;

  assign ifA.shard_start    = shardStart;
  assign ifA.tensor_valid   = tValid;
  assign ifA.tensor_last    = tLast;
  assign ifA.tensor_element = tElem;
  assign ifA.fac_rsp_valid  = rspValid;
  assign ifA.fac_rsp_data   = rspData;
  assign ifA.out_ready      = outReady;
  assign ifB.shard_start    = shardStart;
  assign ifB.tensor_valid   = tValid;
  assign ifB.tensor_last    = tLast;
  assign ifB.tensor_element = tElem;
  assign ifB.fac_rsp_valid  = rspValid;
  assign ifB.fac_rsp_data   = rspData;
  assign ifB.out_ready      = outReady;

  logic             sel;
  logic             tReady, reqValid, oValid, sDone, errOob;
  logic [2*IDX-1:0] reqAddr;
  logic [RB-1:0]    oRow;
  logic [LW-1:0]    oData;

  assign tReady   = sel ? ifB.tensor_ready  : ifA.tensor_ready;
  assign reqValid = sel ? ifB.fac_req_valid : ifA.fac_req_valid;
  assign reqAddr  = sel ? ifB.fac_req_addr  : ifA.fac_req_addr;
  assign oValid   = sel ? ifB.out_valid     : ifA.out_valid;
  assign oRow     = sel ? ifB.out_row       : ifA.out_row;
  assign oData    = sel ? ifB.out_data      : ifA.out_data;
  assign sDone    = sel ? ifB.shard_done    : ifA.shard_done;
  assign errOob   = sel ? ifB.err_oob       : ifA.err_oob;

  int passCount  = 0;
  int checkCount = 0;
  int beatsSeen  = 0;
  int reqPulses  = 0;

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic logic [LW-1:0] lanes(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  typedef struct {
    logic [RB-1:0] row;
    logic [LW-1:0] data;
  } beat_t;

  beat_t expQ[$];
  beat_t monBeat;

  // Scoreboard: every accepted drain beat is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reqValid) reqPulses++;
    if (oValid && outReady) begin
      beatsSeen++;
      if (expQ.size() != 0) begin
        monBeat = expQ.pop_front();
        checkOutput("beat_row", LW'(oRow), LW'(monBeat.row));
        checkOutput("beat_data", oData, monBeat.data);
      end
    end
  end

  task automatic pushExp(input logic [RB-1:0] row, input logic [LW-1:0] data);
    beat_t b;
    b.row  = row;
    b.data = data;
    expQ.push_back(b);
  endtask

  task automatic startShard();
    beatsSeen = 0;
    reqPulses = 0;
    @(posedge clk); #1 shardStart = 1'b1;
    @(posedge clk); #1 shardStart = 1'b0;
  endtask

  task automatic sendRsp(input logic [1:0] mask, input logic [2*LW-1:0] data);
    @(posedge clk); #1;
    rspValid = mask;
    rspData  = data;
    @(posedge clk); #1 rspValid = 2'b00;
  endtask

  // order 0: both modes together; 1: mode 1 three cycles ahead of mode 0;
  // 2: mode 0, then a stale mode-0 repeat carrying garbage, then mode 1.
  task automatic applyStimulus(input logic [IDX-1:0] row, input logic [DW-1:0] val,
                               input logic [LW-1:0] f0, input logic [LW-1:0] f1,
                               input logic last, input int order);
    logic [IDX-1:0] c0, c1;
    int n;
    c0 = IDX'($urandom);
    c1 = IDX'($urandom);
    @(posedge clk); #1;
    tValid = 1'b1;
    tLast  = last;
    tElem  = {row, c1, c0, val};
    n = 0;
    @(negedge clk);
    while (!tReady && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", LW'(tReady), LW'(1));
    @(posedge clk); #1;
    tValid = 1'b0;
    tLast  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!reqValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_valid", LW'(reqValid), LW'(1));
    checkOutput("req_addr", LW'(reqAddr), LW'({c1, c0}));
    if (order == 0) begin
      sendRsp(2'b11, {f1, f0});
    end else if (order == 1) begin
      sendRsp(2'b10, {f1, f0});
      @(posedge clk);
      sendRsp(2'b01, {f1, f0});
    end else begin
      sendRsp(2'b01, {f1, f0});
      @(posedge clk); #1;
      rspValid = 2'b01;
      rspData  = {~f1, ~f0};
      @(posedge clk); #1 rspValid = 2'b00;
      sendRsp(2'b10, {f1, f0});
    end
  endtask

  task automatic waitDone(input int expBeats, input int expReqs, input logic expErr);
    int n;
    n = 0;
    @(negedge clk);
    while (!sDone && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("shard_done", LW'(sDone), LW'(1));
    checkOutput("err_oob", LW'(errOob), LW'(expErr));
    @(negedge clk);
    checkOutput("shard_done_width", LW'(sDone), LW'(0));
    checkOutput("beat_count", LW'(beatsSeen), LW'(expBeats));
    checkOutput("req_pulses", LW'(reqPulses), LW'(expReqs));
    checkOutput("scoreboard_left", LW'(expQ.size()), LW'(0));
    expQ.delete();
  endtask

  task automatic waitOutValid();
    int n;
    n = 0;
    @(negedge clk);
    while (!oValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("out_valid_seen", LW'(oValid), LW'(1));
  endtask

  typedef struct {
    logic [IDX-1:0] row;
    logic [DW-1:0]  val;
    logic [LW-1:0]  f0;
    logic [LW-1:0]  f1;
    logic [LW-1:0]  expData;
    logic           expBeat;
    logic           expErr;
    int             order;
  } vec_t;

  vec_t vecs[6];
  logic activity;

  initial begin
    vecs[0] = '{row: 16'd2,  val: 32'd3, f0: lanes(1, 2, 3, 4), f1: lanes(2, 2, 2, 2),
                expData: lanes(6, 12, 18, 24), expBeat: 1'b1, expErr: 1'b0, order: 0};
    vecs[1] = '{row: 16'd0,  val: 32'd5, f0: lanes(1, 1, 1, 1), f1: lanes(1, 2, 3, 4),
                expData: lanes(5, 10, 15, 20), expBeat: 1'b1, expErr: 1'b0, order: 1};
    vecs[2] = '{row: 16'd15, val: 32'd2, f0: lanes(3, 0, 7, 1), f1: lanes(4, 9, 1, 0),
                expData: lanes(24, 0, 14, 0), expBeat: 1'b1, expErr: 1'b0, order: 2};
    vecs[3] = '{row: 16'd7,  val: 32'hFFFF_FFFF, f0: lanes(2, 2, 2, 2), f1: lanes(2, 2, 2, 2),
                expData: lanes(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC),
                expBeat: 1'b1, expErr: 1'b0, order: 1};
    vecs[4] = '{row: 16'd20, val: 32'd9, f0: lanes(1, 1, 1, 1), f1: lanes(1, 1, 1, 1),
                expData: '0, expBeat: 1'b0, expErr: 1'b1, order: 0};
    vecs[5] = '{row: 16'd9,  val: 32'h0001_0000, f0: lanes(32'h1_0000, 32'h8000, 1, 3),
                f1: lanes(1, 1, 1, 1),
                expData: lanes(0, 32'h8000_0000, 32'h1_0000, 32'h3_0000),
                expBeat: 1'b1, expErr: 1'b0, order: 2};

    sel = 1'b0; rstA = 1'b1; rstB = 1'b1;
    shardStart = 1'b0; tValid = 1'b0; tLast = 1'b0; tElem = '0;
    rspValid = 2'b00; rspData = '0; outReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tensor_ready", LW'(tReady), LW'(0));
    checkOutput("rst_fac_req_valid", LW'(reqValid), LW'(0));
    checkOutput("rst_out_valid", LW'(oValid), LW'(0));
    checkOutput("rst_shard_done", LW'(sDone), LW'(0));
    checkOutput("rst_err_oob", LW'(errOob), LW'(0));
    checkOutput("rst_out_row", LW'(oRow), LW'(0));
    @(posedge clk); #1 rstA = 1'b0;

    $display("[TB] two elements accumulating into row 2");
    pushExp(4'd2, lanes(7, 13, 19, 25));
    startShard();
    applyStimulus(16'd2, 32'd3, lanes(1, 2, 3, 4), lanes(2, 2, 2, 2), 1'b0, 0);
    applyStimulus(16'd2, 32'd1, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 1);
    waitDone(1, 2, 1'b0);

    $display("[TB] single-element vector table");
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].expBeat) pushExp(RB'(vecs[i].row), vecs[i].expData);
      startShard();
      applyStimulus(vecs[i].row, vecs[i].val, vecs[i].f0, vecs[i].f1, 1'b1, vecs[i].order);
      waitDone(vecs[i].expBeat ? 1 : 0, 1, vecs[i].expErr);
    end

    $display("[TB] drain back-pressure then residue-free second shard");
    outReady = 1'b0;
    pushExp(4'd3, lanes(6, 12, 18, 24));
    startShard();
    applyStimulus(16'd3, 32'd3, lanes(1, 2, 3, 4), lanes(2, 2, 2, 2), 1'b1, 0);
    waitOutValid();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", LW'(oValid), LW'(1));
      checkOutput("stall_row", LW'(oRow), LW'(3));
      checkOutput("stall_data", oData, lanes(6, 12, 18, 24));
      @(negedge clk);
    end
    @(posedge clk); #1 outReady = 1'b1;
    waitDone(1, 1, 1'b0);
    pushExp(4'd3, lanes(1, 1, 1, 1));
    pushExp(4'd5, lanes(2, 2, 2, 2));
    startShard();
    applyStimulus(16'd3, 32'd1, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b0, 2);
    applyStimulus(16'd5, 32'd2, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 0);
    waitDone(2, 2, 1'b0);

    $display("[TB] out-of-range row mid-shard, stray shard_start, then flag clear");
    pushExp(4'd4, lanes(4, 4, 4, 4));
    startShard();
    applyStimulus(16'd300, 32'd9, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b0, 0);
    repeat (2) @(negedge clk);
    checkOutput("oob_flag_set", LW'(errOob), LW'(1));
    @(posedge clk); #1 shardStart = 1'b1;
    @(posedge clk); #1 shardStart = 1'b0;
    @(negedge clk);
    checkOutput("oob_flag_sticky", LW'(errOob), LW'(1));
    applyStimulus(16'd4, 32'd4, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 0);
    waitDone(1, 2, 1'b1);
    pushExp(4'd1, lanes(1, 1, 1, 1));
    startShard();
    @(negedge clk);
    checkOutput("oob_flag_cleared", LW'(errOob), LW'(0));
    applyStimulus(16'd1, 32'd1, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 0);
    waitDone(1, 1, 1'b0);

    $display("[TB] reset during fetch with late responses");
    startShard();
    @(posedge clk); #1;
    tValid = 1'b1; tLast = 1'b1; tElem = {16'd6, 16'd1, 16'd2, 32'd7};
    waitOutValid_dummy: begin
      int n;
      n = 0;
      @(negedge clk);
      while (!reqValid && n < 60) begin
        if (tReady) begin
          @(posedge clk); #1 tValid = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      checkOutput("abort_req_seen", LW'(reqValid), LW'(1));
    end
    tValid = 1'b0; tLast = 1'b0;
    @(posedge clk); #1 rstA = 1'b1;
    @(posedge clk); #1 rstA = 1'b0;
    sendRsp(2'b11, {lanes(1, 1, 1, 1), lanes(1, 1, 1, 1)});
    activity = 1'b0;
    repeat (6) begin
      @(negedge clk);
      activity = activity | tReady | oValid | sDone;
    end
    checkOutput("abort_fetch_quiet", LW'(activity), LW'(0));
    pushExp(4'd6, lanes(5, 5, 5, 5));
    startShard();
    applyStimulus(16'd6, 32'd5, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 0);
    waitDone(1, 1, 1'b0);

    $display("[TB] reset during drain clears touched rows");
    outReady = 1'b0;
    startShard();
    applyStimulus(16'd1, 32'd7, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 0);
    waitOutValid();
    @(posedge clk); #1 rstA = 1'b1;
    @(posedge clk); #1 rstA = 1'b0;
    @(negedge clk);
    checkOutput("abort_drain_valid", LW'(oValid), LW'(0));
    checkOutput("abort_drain_row", LW'(oRow), LW'(0));
    outReady = 1'b1;
    pushExp(4'd1, lanes(2, 2, 2, 2));
    startShard();
    applyStimulus(16'd1, 32'd2, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1), 1'b1, 1);
    waitDone(1, 1, 1'b0);

    $display("[TB] full drain instance, single element at last row");
    rstA = 1'b1;
    sel  = 1'b1;
    @(posedge clk); #1 rstB = 1'b0;
    for (int r = 0; r < 15; r++) pushExp(RB'(r), '0);
    pushExp(4'd15, lanes(15, 30, 45, 60));
    startShard();
    applyStimulus(16'd15, 32'd3, lanes(1, 2, 3, 4), lanes(5, 5, 5, 5), 1'b1, 2);
    waitDone(16, 1, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
